// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the latency-configurable data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    // Word address lies inside an array of the given depth.
    function automatic logic addr_in_range(input logic [29:0] addr, input int depth);
        return ({2'b00, addr} < 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Storage for the data-memory responder: byte-enabled synchronous write, combinational read.
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Byte-lane write; disabled lanes keep their contents. No reset on the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_r[addr][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Combinational read port.
    always_comb begin
        rd = mem_r[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready slave for the core's load/store port with a programmable response latency.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_WAIT  = 2'(WAIT);
    localparam logic [1:0] ST_RESP  = 2'(RESP);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic       LAT_ONE  = (LATENCY == 1);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  cnt_r;
    dmem_req_t   req_r;
    dmem_req_t   in_req_s;
    dmem_req_t   commit_req_s;
    dmem_rsp_t   rsp_r;
    logic        rsp_valid_r;
    logic        req_ready_s;
    logic        accept_s;
    logic        enter_resp_s;
    logic        in_range_s;
    logic        mem_we_s;
    logic [31:0] mem_rd_s;

    // Handshake qualifiers; req_ready is held low throughout reset.
    always_comb begin
        req_ready_s = (state_r == ST_IDLE) && !rst;
        accept_s    = req_valid && req_ready_s;
    end

    // With LATENCY==1 the commit happens on the accept edge, so it must use the live request.
    always_comb begin
        in_req_s.we    = req_we;
        in_req_s.addr  = req_addr;
        in_req_s.wdata = req_wdata;
        in_req_s.be    = req_be;
        if (state_r == ST_IDLE) begin
            commit_req_s = in_req_s;
        end else begin
            commit_req_s = req_r;
        end
    end

    // Next-state logic; enter_resp_s marks the commit edge.
    always_comb begin
        state_nxt_s  = state_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LAT_ONE) begin
                        state_nxt_s  = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A reset landing on the commit edge suppresses the write.
    always_comb begin
        in_range_s = addr_in_range(commit_req_s.addr, DEPTH_WORDS);
        mem_we_s   = enter_resp_s && commit_req_s.we && in_range_s && !rst;
    end

    dmem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we_s),
        .be   (commit_req_s.be),
        .addr (commit_req_s.addr[AW-1:0]),
        .wd   (commit_req_s.wdata),
        .rd   (mem_rd_s)
    );

    // FSM, latency counter, request latch and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_r       <= '0;
            rsp_r       <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                req_r <= in_req_s;
                cnt_r <= CNT_INIT;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (enter_resp_s) begin
                rsp_valid_r <= 1'b1;
                rsp_r.err   <= !in_range_s;
                rsp_r.rdata <= (!commit_req_s.we && in_range_s) ? mem_rd_s : 32'd0;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_r.rdata;
    assign rsp_err   = rsp_r.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 4, 1) against a word-array model.
module tb_dmem_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [29:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_be    [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    // Reference: plain word array per instance; out-of-range words are never stored.
    logic [31:0] mdl      [NDUT][DEPTH];
    int          prev_acc [NDUT];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; rsp_ready is held low for `hold` response cycles.
    task automatic run_txn(input int d, input bit we, input logic [29:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int hold, input bit chk_period);
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        logic [31:0] m;
        bit          exp_err;
        bit          seen;
        int          n;
        exp_err = (int'(addr) >= DEPTH) || (addr[29:20] != 10'd0);
        if (we) begin
            exp_rdata = 32'd0;
            if (!exp_err) begin
                m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                mdl[d][int'(addr)] = (mdl[d][int'(addr)] & ~m) | (wdata & m);
            end
        end else begin
            exp_rdata = exp_err ? 32'd0 : mdl[d][int'(addr)];
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = (hold == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        if (chk_period) check_eq("accept_period", 32'(cyc - prev_acc[d]), 32'(lat_of(d) + 1));
        prev_acc[d]  = cyc;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 30'($urandom);
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = rsp_valid[d];
        end
        check_eq("rsp_latency", 32'(n), 32'(lat_of(d)));
        got_rdata = rsp_rdata[d];
        check_eq("rsp_rdata", got_rdata, exp_rdata);
        check_eq("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        check_eq("req_ready_busy", 32'(req_ready[d]), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid[d]), 32'd1);
            check_eq("bp_rdata", rsp_rdata[d], got_rdata);
            check_eq("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("retire_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("retire_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata[d], 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready[d]), 32'd0);
    endtask

    task automatic random_phase(input int d, input int count);
        logic [29:0] a;
        for (int i = 0; i < 32; i++) run_txn(d, 1'b1, 30'(i), $urandom, 4'hF, 0, 1'b0);
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 30'(DEPTH + $urandom_range(0, 8));
                1:       a = 30'h3FFF_FFFF;
                default: a = 30'($urandom_range(0, 31));
            endcase
            run_txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 30'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b1; prev_acc[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_reset_outputs(d);
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) check_eq("post_rst_req_ready", 32'(req_ready[d]), 32'd1);
        @(negedge clk);

        // Directed cases on the LATENCY=2 instance.
        for (int i = 0; i < 32; i++) run_txn(0, 1'b1, 30'(i), $urandom, 4'hF, 0, 1'b0);
        run_txn(0, 1'b1, 30'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        run_txn(0, 1'b0, 30'h10, 32'd0, 4'h0, 0, 1'b1);
        check_eq("model_store_load", mdl[0][16], 32'hDEAD_BEEF);
        run_txn(0, 1'b1, 30'h14, 32'h1122_3344, 4'hF, 0, 1'b1);
        run_txn(0, 1'b1, 30'h14, 32'hAABB_CCDD, 4'b0101, 0, 1'b1);
        run_txn(0, 1'b0, 30'h14, 32'd0, 4'h0, 0, 1'b1);
        check_eq("model_byte_mask", mdl[0][20], 32'h11BB_33DD);
        run_txn(0, 1'b0, 30'h14, 32'd0, 4'h0, 5, 1'b0);
        run_txn(0, 1'b1, 30'd1024, 32'h5555_AAAA, 4'hF, 0, 1'b0);
        run_txn(0, 1'b0, 30'd1024, 32'd0, 4'h0, 0, 1'b1);
        run_txn(0, 1'b0, 30'd0, 32'd0, 4'h0, 0, 1'b1);
        run_txn(0, 1'b1, 30'h10, 32'h0BAD_0BAD, 4'h0, 0, 1'b1);
        run_txn(0, 1'b0, 30'h10, 32'd0, 4'h0, 0, 1'b1);
        random_phase(0, 40);

        // Reset during WAIT on the LATENCY=4 instance: the store must vanish.
        for (int i = 0; i < 8; i++) run_txn(1, 1'b1, 30'(i), $urandom, 4'hF, 0, 1'b0);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 30'd5;
        req_wdata[1] = 32'hCAFE_F00D; req_be[1] = 4'hF; rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(1);
        rst[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("wait_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
            check_eq("wait_rst_req_ready", 32'(req_ready[1]), 32'd1);
        end
        run_txn(1, 1'b0, 30'd5, 32'd0, 4'h0, 0, 1'b0);
        random_phase(1, 30);

        // LATENCY=1: back-to-back loads, accepts every two cycles.
        for (int i = 0; i < 8; i++) run_txn(2, 1'b1, 30'(i), $urandom, 4'hF, 0, 1'b0);
        run_txn(2, 1'b0, 30'd0, 32'd0, 4'h0, 0, 1'b0);
        for (int i = 1; i < 8; i++) run_txn(2, 1'b0, 30'(i), 32'd0, 4'h0, 0, 1'b1);
        random_phase(2, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
